// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bridge: FSM encoding, default IO window and
// the fixed channel assignments of the board peripherals.
package mmio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEM_ACC = 2'd1,
      ST_IO_ACC  = 2'd2,
      ST_DONE    = 2'd3
   } mmio_state_e;

   localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_FC60;
   localparam int          CH_LED      = 0;
   localparam int          CH_SWITCH   = 1;
   localparam int          WCNT_W      = 4;

   // Word-offset width inside one channel; a 4-byte channel still gets one bit.
   function automatic int io_reg_w(input int stride);
      return ($clog2(stride) > 3) ? $clog2(stride) - 2 : 1;
   endfunction

endpackage

// File: rtl/mmio_decode.sv
// Combinational IO window decode: address -> mapped flag, one-hot channel
// select and word offset. Shared with the debug bus.
module mmio_decode
   import mmio_pkg::*;
#(
   parameter int          IO_CH     = 4,
   parameter logic [31:0] IO_BASE   = IO_BASE_DEF,
   parameter int          CH_STRIDE = 16
) (
   input  logic [31:0]                     caddress,
   output logic                            mapped,
   output logic [IO_CH-1:0]                ch_sel,
   output logic [io_reg_w(CH_STRIDE)-1:0]  io_reg
);

   localparam int          SH   = $clog2(CH_STRIDE);
   localparam logic [31:0] SPAN = 32'(IO_CH * CH_STRIDE);

   logic [31:0] off;
   logic [31:0] ch_idx;

   // IO_BASE is word aligned, so the low offset bits equal the address bits.
   always_comb begin
      off    = caddress - IO_BASE;
      mapped = (off < SPAN) && (off[1:0] == 2'b00);
      ch_idx = off >> SH;
      ch_sel = '0;
      for (int k = 0; k < IO_CH; k++) begin
         ch_sel[k] = mapped && (ch_idx == 32'(k));
      end
   end

   generate
      if (SH > 2) begin : g_reg
         assign io_reg = mapped ? off[SH-1:2] : '0;
      end else begin : g_noreg
         assign io_reg = '0;
      end
   endgenerate

endmodule

// File: rtl/mmio_bridge.sv
// Multi-cycle bridge from the memory stage to data RAM and IO channels, with
// programmable wait states, pipeline stall and bus error reporting.
//
//  state   | meaning
//  IDLE    | waiting for a request; stall follows the request combinationally
//  MEM_ACC | RAM strobe held for MEM_WAIT+1 cycles
//  IO_ACC  | IO strobe and chip select held for IO_WAIT+1 cycles
//  DONE    | one cycle, stall released, bus_err reported, requests ignored
module mmio_bridge
   import mmio_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          IO_DW     = 16,
   parameter int          IO_CH     = 4,
   parameter logic [31:0] IO_BASE   = IO_BASE_DEF,
   parameter int          CH_STRIDE = 16,
   parameter int          MEM_WAIT  = 0,
   parameter int          IO_WAIT   = 1
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [31:0]                     caddress,
   input  logic [DATA_W-1:0]               wdata,
   input  logic                            memread,
   input  logic                            memwrite,
   input  logic                            ioread,
   input  logic                            iowrite,
   output logic                            cpu_stall,
   output logic [DATA_W-1:0]               rdata,
   output logic                            bus_err,
   output logic [31:0]                     mem_addr,
   output logic                            mem_rd,
   output logic                            mem_wr,
   output logic [DATA_W-1:0]               mem_wdata,
   input  logic [DATA_W-1:0]               mem_rdata,
   output logic [IO_CH-1:0]                io_cs,
   output logic [io_reg_w(CH_STRIDE)-1:0]  io_reg,
   output logic                            io_rd,
   output logic                            io_wr,
   output logic [IO_DW-1:0]                io_wdata,
   input  logic [IO_CH*IO_DW-1:0]          io_rdata
);

   localparam int REG_W = io_reg_w(CH_STRIDE);

   mmio_state_e         state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q;
   logic                err_q;
   logic                rd_q;
   logic                wr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [31:0]         mem_addr_q;
   logic [IO_CH-1:0]    cs_q;
   logic [REG_W-1:0]    reg_q;

   logic                dec_mapped;
   logic [IO_CH-1:0]    dec_cs;
   logic [REG_W-1:0]    dec_reg;

   logic                req;
   logic                io_req;
   logic [2:0]          n_req;
   logic                bad;
   logic [IO_DW-1:0]    io_sel;

   mmio_decode #(
      .IO_CH     (IO_CH),
      .IO_BASE   (IO_BASE),
      .CH_STRIDE (CH_STRIDE)
   ) u_decode (
      .caddress (caddress),
      .mapped   (dec_mapped),
      .ch_sel   (dec_cs),
      .io_reg   (dec_reg)
   );

   always_comb begin
      req    = memread | memwrite | ioread | iowrite;
      io_req = ioread | iowrite;
      n_req  = {2'b00, memread} + {2'b00, memwrite} + {2'b00, ioread} + {2'b00, iowrite};
      bad    = (n_req > 3'd1) || (io_req && !dec_mapped);
   end

   always_comb begin
      io_sel = '0;
      for (int k = 0; k < IO_CH; k++) begin
         if (cs_q[k]) io_sel = io_sel | io_rdata[k*IO_DW +: IO_DW];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (bad)         state_d = ST_DONE;
               else if (io_req) state_d = ST_IO_ACC;
               else             state_d = ST_MEM_ACC;
            end
         end
         ST_MEM_ACC, ST_IO_ACC: begin
            if (wcnt_q == '0) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         wcnt_q     <= '0;
         err_q      <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         mem_addr_q <= '0;
         cs_q       <= '0;
         reg_q      <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            ST_IDLE: begin
               if (req) begin
                  err_q   <= bad;
                  rd_q    <= memread | ioread;
                  wr_q    <= memwrite | iowrite;
                  wdata_q <= wdata;
                  if (!bad && io_req) begin
                     cs_q   <= dec_cs;
                     reg_q  <= dec_reg;
                     wcnt_q <= WCNT_W'(IO_WAIT);
                  end else begin
                     cs_q   <= '0;
                     reg_q  <= '0;
                     wcnt_q <= WCNT_W'(MEM_WAIT);
                  end
                  if (!bad && !io_req) mem_addr_q <= caddress;
               end
            end
            ST_MEM_ACC, ST_IO_ACC: begin
               if (wcnt_q != '0) begin
                  wcnt_q <= wcnt_q - 1'b1;
               end else if (rd_q) begin
                  rdata_q <= (state_q == ST_MEM_ACC) ? mem_rdata : DATA_W'(io_sel);
               end
            end
            ST_DONE: err_q <= 1'b0;
            default: ;
         endcase
      end
   end

   // Strobes decode straight from state so an async reset removes them at once.
   always_comb begin
      cpu_stall = ((state_q == ST_IDLE) && req) ||
                  (state_q == ST_MEM_ACC) || (state_q == ST_IO_ACC);
      mem_rd    = (state_q == ST_MEM_ACC) && rd_q;
      mem_wr    = (state_q == ST_MEM_ACC) && wr_q;
      io_rd     = (state_q == ST_IO_ACC) && rd_q;
      io_wr     = (state_q == ST_IO_ACC) && wr_q;
      io_cs     = (state_q == ST_IO_ACC) ? cs_q : '0;
      io_reg    = (state_q == ST_IO_ACC) ? reg_q : '0;
      mem_wdata = mem_wr ? wdata_q : '0;
      io_wdata  = io_wr ? wdata_q[IO_DW-1:0] : '0;
      bus_err   = (state_q == ST_DONE) && err_q;
      rdata     = rdata_q;
      mem_addr  = mem_addr_q;
   end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: default-wait instance plus a MEM_WAIT=3 /
// IO_WAIT=0 instance sharing the request inputs.
module tb_mmio_bridge;
   import mmio_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   always #5 clock = ~clock;

   logic [31:0] caddress = '0;
   logic [31:0] wdata = '0;
   logic        memread = 1'b0, memwrite = 1'b0, ioread = 1'b0, iowrite = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [63:0] io_rdata = '0;

   logic        stall0, err0, mrd0, mwr0, ird0, iwr0;
   logic [31:0] rdata0, maddr0, mwd0;
   logic [3:0]  cs0;
   logic [1:0]  reg0;
   logic [15:0] iwd0;

   logic        stall1, err1, mrd1, mwr1, ird1, iwr1;
   logic [31:0] rdata1, maddr1, mwd1;
   logic [3:0]  cs1;
   logic [1:0]  reg1;
   logic [15:0] iwd1;

   mmio_bridge dut0 (
      .clock(clock), .reset(reset), .caddress(caddress), .wdata(wdata),
      .memread(memread), .memwrite(memwrite), .ioread(ioread), .iowrite(iowrite),
      .cpu_stall(stall0), .rdata(rdata0), .bus_err(err0), .mem_addr(maddr0),
      .mem_rd(mrd0), .mem_wr(mwr0), .mem_wdata(mwd0), .mem_rdata(mem_rdata),
      .io_cs(cs0), .io_reg(reg0), .io_rd(ird0), .io_wr(iwr0), .io_wdata(iwd0),
      .io_rdata(io_rdata)
   );

   mmio_bridge #(.MEM_WAIT(3), .IO_WAIT(0)) dut1 (
      .clock(clock), .reset(reset), .caddress(caddress), .wdata(wdata),
      .memread(memread), .memwrite(memwrite), .ioread(ioread), .iowrite(iowrite),
      .cpu_stall(stall1), .rdata(rdata1), .bus_err(err1), .mem_addr(maddr1),
      .mem_rd(mrd1), .mem_wr(mwr1), .mem_wdata(mwd1), .mem_rdata(mem_rdata),
      .io_cs(cs1), .io_reg(reg1), .io_rd(ird1), .io_wr(iwr1), .io_wdata(iwd1),
      .io_rdata(io_rdata)
   );

   logic        sel = 1'b0;
   logic        o_stall, o_err, o_strb;
   logic [3:0]  o_kind;
   logic [31:0] o_rdata, o_maddr, o_mwd;
   logic [3:0]  o_cs;
   logic [1:0]  o_reg;
   logic [15:0] o_iwd;

   always_comb begin
      o_stall = sel ? stall1 : stall0;
      o_err   = sel ? err1 : err0;
      o_kind  = sel ? {mrd1, mwr1, ird1, iwr1} : {mrd0, mwr0, ird0, iwr0};
      o_strb  = |o_kind;
      o_rdata = sel ? rdata1 : rdata0;
      o_maddr = sel ? maddr1 : maddr0;
      o_mwd   = sel ? mwd1 : mwd0;
      o_cs    = sel ? cs1 : cs0;
      o_reg   = sel ? reg1 : reg0;
      o_iwd   = sel ? iwd1 : iwd0;
   end

   int tests = 0;
   int fails = 0;

   int          n_stall, n_strobe;
   logic [3:0]  r_seen, r_cs;
   logic [1:0]  r_reg;
   logic [15:0] r_iwd;
   logic [31:0] r_maddr, r_mwd, r_rdata;
   logic        r_err, r_pre, r_done_strb;

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic apply_reset();
      {memread, memwrite, ioread, iowrite} = 4'b0000;
      @(posedge clock);
      #3 reset = 1'b0;
      #1 reset = 1'b1;
      step();
   endtask

   // Drives one request (kind = {memread,memwrite,ioread,iowrite}) until the
   // bridge reaches DONE; b2b means the call starts inside a previous DONE.
   task automatic do_access(input logic s, input logic [3:0] kind,
                            input logic [31:0] a, input logic [31:0] d, input logic b2b);
      sel = s;
      caddress = a;
      wdata = d;
      {memread, memwrite, ioread, iowrite} = kind;
      n_stall = 0; n_strobe = 0; r_seen = '0; r_cs = '0; r_reg = '0;
      r_iwd = '0; r_maddr = '0; r_mwd = '0; r_pre = 1'b0;
      #1;
      if (b2b) begin
         r_pre = o_stall | o_strb;
         step();
      end
      while (o_stall && n_stall < 40) begin
         n_stall++;
         if (o_strb) begin
            n_strobe++;
            r_seen = r_seen | o_kind;
            r_cs = o_cs; r_reg = o_reg; r_iwd = o_iwd; r_maddr = o_maddr; r_mwd = o_mwd;
         end
         step();
      end
      if (n_stall >= 40) begin
         tests++; fails++;
         $display("FAIL timeout: stall still high after %0d cycles, required release", n_stall);
      end
      r_rdata = o_rdata;
      r_err = o_err;
      r_done_strb = o_strb;
      {memread, memwrite, ioread, iowrite} = 4'b0000;
   endtask

   task automatic test_reset();
      {memread, memwrite, ioread, iowrite} = 4'b0000;
      reset = 1'b0;
      #7;
      tests++; if (stall0 !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall0); end
      tests++; if (rdata0 !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata0); end
      tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL reset_bus_err: got %b want 0", err0); end
      tests++; if ({mrd0, mwr0, ird0, iwr0} !== 4'b0000) begin fails++;
         $display("FAIL reset_strobes: got %b want 0000", {mrd0, mwr0, ird0, iwr0}); end
      tests++; if (cs0 !== 4'b0000) begin fails++; $display("FAIL reset_io_cs: got %b want 0000", cs0); end
      tests++; if (maddr0 !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h want 0", maddr0); end
      tests++; if ({mwd0, iwd0, reg0} !== 50'h0) begin fails++;
         $display("FAIL reset_wdata_reg: got %h want 0", {mwd0, iwd0, reg0}); end
      tests++; if ({stall1, rdata1, err1} !== 34'h0) begin fails++;
         $display("FAIL reset_dut1: got %h want 0", {stall1, rdata1, err1}); end
      reset = 1'b1;
      step();
   endtask

   task automatic test_mem_read();
      apply_reset();
      mem_rdata = 32'hDEAD_BEEF;
      do_access(1'b0, 4'b1000, 32'h0000_0040, 32'h0, 1'b0);
      tests++; if (n_stall != 2) begin fails++; $display("FAIL memrd_stall_cycles: got %0d want 2", n_stall); end
      tests++; if (n_strobe != 1 || r_seen !== 4'b1000) begin fails++;
         $display("FAIL memrd_strobe: got %0d cycles kind %b want 1 cycle kind 1000", n_strobe, r_seen); end
      tests++; if (r_maddr !== 32'h0000_0040) begin fails++; $display("FAIL memrd_addr: got %h want 00000040", r_maddr); end
      tests++; if (r_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL memrd_rdata: got %h want deadbeef", r_rdata); end
      tests++; if (r_err !== 1'b0 || r_done_strb !== 1'b0) begin fails++;
         $display("FAIL memrd_done: got err %b strobe %b want 0 0", r_err, r_done_strb); end
      step();
   endtask

   task automatic test_io_write();
      apply_reset();
      do_access(1'b0, 4'b0001, 32'hFFFF_FC60, 32'h1234_ABCD, 1'b0);
      tests++; if (r_cs !== 4'b0001) begin fails++; $display("FAIL iowr_cs: got %b want 0001", r_cs); end
      tests++; if (n_strobe != 2 || r_seen !== 4'b0001) begin fails++;
         $display("FAIL iowr_strobe: got %0d cycles kind %b want 2 cycles kind 0001", n_strobe, r_seen); end
      tests++; if (r_iwd !== 16'hABCD) begin fails++; $display("FAIL iowr_wdata: got %h want abcd", r_iwd); end
      tests++; if (r_mwd !== 32'h0) begin fails++; $display("FAIL iowr_mem_wdata: got %h want 0", r_mwd); end
      tests++; if (r_err !== 1'b0 || n_stall != 3) begin fails++;
         $display("FAIL iowr_done: got err %b stall %0d want 0 3", r_err, n_stall); end
      step();
   endtask

   task automatic test_io_read();
      apply_reset();
      io_rdata = {16'hBEEF, 16'h7777, 16'h00F0, 16'h5555};
      do_access(1'b0, 4'b0010, 32'hFFFF_FC70, 32'h0, 1'b0);
      tests++; if (r_cs !== 4'b0010 || r_reg !== 2'd0) begin fails++;
         $display("FAIL iord_ch1_sel: got cs %b reg %0d want 0010 0", r_cs, r_reg); end
      tests++; if (r_rdata !== 32'h0000_00F0) begin fails++; $display("FAIL iord_ch1_rdata: got %h want 000000f0", r_rdata); end
      tests++; if (n_stall + 1 != 4) begin fails++; $display("FAIL iord_total_cycles: got %0d want 4", n_stall + 1); end
      step();
      do_access(1'b0, 4'b0010, 32'hFFFF_FC74, 32'h0, 1'b0);
      tests++; if (r_cs !== 4'b0010 || r_reg !== 2'd1) begin fails++;
         $display("FAIL iord_reg1: got cs %b reg %0d want 0010 1", r_cs, r_reg); end
      step();
      do_access(1'b0, 4'b0010, 32'hFFFF_FC9C, 32'h0, 1'b0);
      tests++; if (r_cs !== 4'b1000 || r_reg !== 2'd3 || r_err !== 1'b0) begin fails++;
         $display("FAIL iord_last_word: got cs %b reg %0d err %b want 1000 3 0", r_cs, r_reg, r_err); end
      tests++; if (r_rdata !== 32'h0000_BEEF) begin fails++; $display("FAIL iord_ch3_rdata: got %h want 0000beef", r_rdata); end
      step();
      do_access(1'b0, 4'b0001, 32'hFFFF_FC60, 32'hFFFF_0001, 1'b0);
      tests++; if (r_rdata !== 32'h0000_BEEF) begin fails++; $display("FAIL write_keeps_rdata: got %h want 0000beef", r_rdata); end
      step();
   endtask

   task automatic test_errors();
      apply_reset();
      do_access(1'b0, 4'b0010, 32'hFFFF_FCA0, 32'h0, 1'b0);
      tests++; if (n_strobe != 0 || n_stall != 1 || r_err !== 1'b1) begin fails++;
         $display("FAIL unmapped_io: got strobes %0d stall %0d err %b want 0 1 1", n_strobe, n_stall, r_err); end
      step();
      tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL unmapped_pulse: got %b want 0 after DONE", err0); end
      do_access(1'b0, 4'b1001, 32'h0000_0040, 32'h0, 1'b0);
      tests++; if (n_strobe != 0 || n_stall != 1 || r_err !== 1'b1) begin fails++;
         $display("FAIL multi_req: got strobes %0d stall %0d err %b want 0 1 1", n_strobe, n_stall, r_err); end
      step();
      tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL multi_pulse: got %b want 0 after DONE", err0); end
      do_access(1'b0, 4'b0010, 32'hFFFF_FC62, 32'h0, 1'b0);
      tests++; if (n_strobe != 0 || r_err !== 1'b1) begin fails++;
         $display("FAIL misaligned_io: got strobes %0d err %b want 0 1", n_strobe, r_err); end
      step();
   endtask

   task automatic test_reset_midflight();
      apply_reset();
      io_rdata = {16'hBEEF, 16'h7777, 16'h00F0, 16'h5555};
      do_access(1'b0, 4'b0010, 32'hFFFF_FC70, 32'h0, 1'b0);
      step();
      sel = 1'b0;
      caddress = 32'hFFFF_FC60;
      wdata = 32'h0000_5A5A;
      iowrite = 1'b1;
      step();
      tests++; if (iwr0 !== 1'b1 || cs0 !== 4'b0001 || rdata0 !== 32'h0000_00F0) begin fails++;
         $display("FAIL midflight_setup: got io_wr %b cs %b rdata %h want 1 0001 000000f0", iwr0, cs0, rdata0); end
      #2 reset = 1'b0;
      #1;
      tests++; if (iwr0 !== 1'b0 || cs0 !== 4'b0000 || iwd0 !== 16'h0) begin fails++;
         $display("FAIL midflight_async_drop: got io_wr %b cs %b wdata %h want 0 0000 0000", iwr0, cs0, iwd0); end
      tests++; if (rdata0 !== 32'h0) begin fails++; $display("FAIL midflight_rdata: got %h want 0", rdata0); end
      iowrite = 1'b0;
      #1;
      tests++; if (stall0 !== 1'b0 || err0 !== 1'b0) begin fails++;
         $display("FAIL midflight_idle: got stall %b err %b want 0 0", stall0, err0); end
      reset = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      io_rdata = {16'hBEEF, 16'h7777, 16'h00F0, 16'h5555};
      do_access(1'b1, 4'b0100, 32'h0000_0100, 32'hCAFE_F00D, 1'b0);
      tests++; if (n_stall != 5) begin fails++; $display("FAIL b2b_memwr_cycles: got %0d want 5", n_stall); end
      tests++; if (r_seen !== 4'b0100 || r_mwd !== 32'hCAFE_F00D || r_maddr !== 32'h0000_0100) begin fails++;
         $display("FAIL b2b_memwr_bus: got kind %b data %h addr %h want 0100 cafef00d 00000100", r_seen, r_mwd, r_maddr); end
      do_access(1'b1, 4'b0010, 32'hFFFF_FC70, 32'h0, 1'b1);
      tests++; if (r_pre !== 1'b0) begin fails++; $display("FAIL b2b_ignored_in_done: got %b want 0", r_pre); end
      tests++; if (n_stall + 1 != 3) begin fails++; $display("FAIL b2b_iord_cycles: got %0d want 3", n_stall + 1); end
      tests++; if (r_rdata !== 32'h0000_00F0 || r_cs !== 4'b0010 || r_err !== 1'b0) begin fails++;
         $display("FAIL b2b_iord_data: got rdata %h cs %b err %b want 000000f0 0010 0", r_rdata, r_cs, r_err); end
      step();
   endtask

   initial begin
      test_reset();
      test_mem_read();
      test_io_write();
      test_io_read();
      test_errors();
      test_reset_midflight();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
